// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle RV32I main controller: major opcodes,
// FSM state encoding, datapath select codes and the instruction-class vector.
package ctrl_pkg;

  // RV32I major opcodes (irOut[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  // Controller states, 3-bit encoding
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  // Next-PC source select
  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JAL    = 2'b10,
    PC_JALR   = 2'b11
  } pc_sel_e;

  // Register-file write-back source select
  typedef enum logic [1:0] {
    M2R_ALU  = 2'b00,
    M2R_RAM  = 2'b01,
    M2R_LINK = 2'b10,
    M2R_IMM  = 2'b11
  } mem_to_reg_e;

  // One-hot instruction class; exactly one bit is set for any opcode
  typedef struct packed {
    logic alu;    // OP (register-register)
    logic imm;    // OP-IMM
    logic lui;
    logic auipc;
    logic br;
    logic jal;
    logic jalr;
    logic ld;
    logic st;
    logic sys;    // ECALL / EBREAK
    logic bad;    // anything unsupported
  } insn_class_t;

endpackage

// File: rtl/control_unit_if.sv
// Controller <-> datapath signal bundle. The master side is the controller,
// the slave side is the datapath (and whoever supplies run).
interface control_unit_if #(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 32
);
  logic              run;
  logic [DWIDTH-1:0] irOut;
  logic              comparatorOut;
  logic              irEn;
  logic              pcEn;
  logic [1:0]        pcSelect;
  logic              regWrite;
  logic              aluSrc;
  logic              ramRdEn;
  logic              ramWrEn;
  logic              isByte;
  logic              isHalf;
  logic              isWord;
  logic [1:0]        memToReg;
  logic              illegal;
  logic              halted;
  logic [CNT_W-1:0]  instret;

  modport master (
    input  run, irOut, comparatorOut,
    output irEn, pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
           isByte, isHalf, isWord, memToReg, illegal, halted, instret
  );

  modport slave (
    output run, irOut, comparatorOut,
    input  irEn, pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
           isByte, isHalf, isWord, memToReg, illegal, halted, instret
  );
endinterface

// File: rtl/insn_class.sv
// Combinational opcode classifier: maps irOut[6:0] onto a one-hot class vector.
module insn_class
  import ctrl_pkg::*;
(
  input  logic [6:0]  opcode,
  output insn_class_t cls
);

  // Decode the major opcode; unknown encodings fall into the 'bad' class
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (no latch).
    cls = '0;
    case (opcode)
      OPC_OP:     cls.alu   = 1'b1;
      OPC_OP_IMM: cls.imm   = 1'b1;
      OPC_LUI:    cls.lui   = 1'b1;
      OPC_AUIPC:  cls.auipc = 1'b1;
      OPC_BRANCH: cls.br    = 1'b1;
      OPC_JAL:    cls.jal   = 1'b1;
      OPC_JALR:   cls.jalr  = 1'b1;
      OPC_LOAD:   cls.ld    = 1'b1;
      OPC_STORE:  cls.st    = 1'b1;
      OPC_SYSTEM: cls.sys   = 1'b1;
      default:    cls.bad   = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multicycle RV32I main controller. Walks each instruction through
// FETCH/DECODE/EXEC[/MEM[/WB]], drives every datapath enable/select from the
// current state and IR, halts on SYSTEM, and counts retired instructions.
// Only the state and the retire counter are registered; while reset is low
// every output is forced to 0 so no write strobe survives into reset.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int CNT_W  = 32
)(
  input  logic           clk,
  input  logic           reset,   // asynchronous, active-low
  control_unit_if.master bus
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  insn_class_t      cls;
  logic [1:0]       size_sel;

  // Raw (ungated) control decisions from the FSM
  logic        ir_en, pc_en, reg_write, alu_src, ram_rd, ram_wr, size_en;
  logic        illegal, halted;
  pc_sel_e     pc_select;
  mem_to_reg_e mem_to_reg;

  // Instruction fields not needed by the controller itself; the branch
  // outcome is applied by the datapath's PC mux, not by the FSM.
  logic unused_bits;
  assign unused_bits = ^{bus.irOut[DWIDTH-1:14], bus.irOut[11:7], bus.comparatorOut};

  assign size_sel = bus.irOut[13:12];

  insn_class u_insn_class (
    .opcode (bus.irOut[6:0]),
    .cls    (cls)
  );

  // State register and retired-instruction counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      instret_q <= '0;
    end else begin
      // NOTE: registered state uses non-blocking assignment so all flops update from pre-edge values.
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  // Next-state and per-state datapath controls
  always_comb begin
    state_d    = state_q;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pc_select  = PC_PLUS4;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    ram_rd     = 1'b0;
    ram_wr     = 1'b0;
    size_en    = 1'b0;
    mem_to_reg = M2R_ALU;
    illegal    = 1'b0;
    halted     = 1'b0;

    case (state_q)
      S_FETCH: begin
        ir_en = bus.run;
        if (bus.run) state_d = S_DECODE;
      end

      // Register file and immediate generator settle; no strobes
      S_DECODE: state_d = S_EXEC;

      S_EXEC: begin
        state_d = S_FETCH;
        if (cls.alu || cls.imm || cls.auipc) begin
          reg_write = 1'b1;
          alu_src   = !cls.alu;
          pc_en     = 1'b1;
        end else if (cls.lui) begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_IMM;
          pc_en      = 1'b1;
        end else if (cls.br) begin
          pc_en     = 1'b1;
          pc_select = PC_BRANCH;
        end else if (cls.jal || cls.jalr) begin
          reg_write  = 1'b1;
          mem_to_reg = M2R_LINK;
          pc_en      = 1'b1;
          pc_select  = cls.jalr ? PC_JALR : PC_JAL;
          alu_src    = cls.jalr;
        end else if (cls.ld || cls.st) begin
          alu_src = 1'b1;
          size_en = 1'b1;
          state_d = S_MEM;
        end else if (cls.sys) begin
          state_d = S_HALT;
        end else begin
          illegal = 1'b1;
          pc_en   = 1'b1;
        end
      end

      // Address stays on the ALU; size lines held for the RAM access
      S_MEM: begin
        alu_src = 1'b1;
        size_en = 1'b1;
        if (cls.ld) begin
          ram_rd  = 1'b1;
          state_d = S_WB;
        end else begin
          ram_wr  = 1'b1;
          pc_en   = 1'b1;
          state_d = S_FETCH;
        end
      end

      // Load data written back; read and size held so the RAM output stays valid
      S_WB: begin
        alu_src    = 1'b1;
        size_en    = 1'b1;
        ram_rd     = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = M2R_RAM;
        pc_en      = 1'b1;
        state_d    = S_FETCH;
      end

      S_HALT: halted = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

  // Retire on every final cycle that advances the PC, except an illegal op
  always_comb begin
    instret_d = instret_q;
    if (pc_en && !illegal) instret_d = instret_q + CNT_W'(1);
  end

  // Outputs forced low for as long as reset is held
  assign bus.irEn     = reset & ir_en;
  assign bus.pcEn     = reset & pc_en;
  assign bus.pcSelect = reset ? pc_select : PC_PLUS4;
  assign bus.regWrite = reset & reg_write;
  assign bus.aluSrc   = reset & alu_src;
  assign bus.ramRdEn  = reset & ram_rd;
  assign bus.ramWrEn  = reset & ram_wr;
  assign bus.isByte   = reset & size_en & (size_sel == 2'b00);
  assign bus.isHalf   = reset & size_en & (size_sel == 2'b01);
  assign bus.isWord   = reset & size_en & (size_sel == 2'b10);
  assign bus.memToReg = reset ? mem_to_reg : M2R_ALU;
  assign bus.illegal  = reset & illegal;
  assign bus.halted   = reset & halted;
  assign bus.instret  = instret_q;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: a table of single-pass instructions checked
// cycle by cycle, plus hand sequences for memory ops, run stall, mid-instruction
// reset, halt, and counter wrap on a narrow-counter instance.
module tb_control_unit;

  // Packed output view: [14]irEn [13]pcEn [12:11]pcSelect [10]regWrite [9]aluSrc
  // [8]ramRdEn [7]ramWrEn [6]isByte [5]isHalf [4]isWord [3:2]memToReg [1]illegal [0]halted
  localparam logic [14:0] E_IREN     = 15'h4000;
  localparam logic [14:0] E_PCEN     = 15'h2000;
  localparam logic [14:0] E_SEL_BR   = 15'h0800;
  localparam logic [14:0] E_SEL_JAL  = 15'h1000;
  localparam logic [14:0] E_SEL_JALR = 15'h1800;
  localparam logic [14:0] E_RW       = 15'h0400;
  localparam logic [14:0] E_AS       = 15'h0200;
  localparam logic [14:0] E_RD       = 15'h0100;
  localparam logic [14:0] E_WR       = 15'h0080;
  localparam logic [14:0] E_BYTE     = 15'h0040;
  localparam logic [14:0] E_HALF     = 15'h0020;
  localparam logic [14:0] E_WORD     = 15'h0010;
  localparam logic [14:0] E_M2R_RAM  = 15'h0004;
  localparam logic [14:0] E_M2R_LINK = 15'h0008;
  localparam logic [14:0] E_M2R_IMM  = 15'h000C;
  localparam logic [14:0] E_ILL      = 15'h0002;
  localparam logic [14:0] E_HALT     = 15'h0001;
  localparam logic [14:0] E_ALL      = 15'h7FFF;
  localparam logic [14:0] E_NONE     = 15'h0000;

  localparam logic [31:0] IR_ADD   = 32'h00308133;
  localparam logic [31:0] IR_LW    = 32'h0040A103;
  localparam logic [31:0] IR_SB    = 32'h00208023;
  localparam logic [31:0] IR_SH    = 32'h00209023;
  localparam logic [31:0] IR_ECALL = 32'h00000073;

  typedef struct {
    string       name;
    logic [31:0] ir;
    logic        cmp;
    logic [14:0] exp;     // expected outputs in the EXEC cycle
    bit          retire;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n, rst4_n;
  int   errors = 0;
  int   checks = 0;
  logic [31:0] exp_instret = '0;
  vec_t vecs[10];

  always #5 clk = ~clk;

  control_unit_if #(.DWIDTH(32), .CNT_W(32)) bus ();
  control_unit_if #(.DWIDTH(32), .CNT_W(4))  bus4 ();

  control_unit #(.DWIDTH(32), .CNT_W(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.master)
  );

  control_unit #(.DWIDTH(32), .CNT_W(4)) dut4 (
    .clk   (clk),
    .reset (rst4_n),
    .bus   (bus4.master)
  );

  function automatic logic [14:0] outs_now();
    return {bus.irEn, bus.pcEn, bus.pcSelect, bus.regWrite, bus.aluSrc,
            bus.ramRdEn, bus.ramWrEn, bus.isByte, bus.isHalf, bus.isWord,
            bus.memToReg, bus.illegal, bus.halted};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [14:0] exp, input logic [14:0] mask);
    check(name, {17'b0, outs_now() & mask}, {17'b0, exp & mask});
  endtask

  // Advance one clock; land 2 time units after the rising edge
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Full load/store pass starting in FETCH with run=1
  task automatic do_mem(input string name, input logic [31:0] ir, input bit is_load,
                        input logic [14:0] size_bit);
    bus.irOut = ir;
    bus.run   = 1'b1;
    #1 check_outs({name, "_fetch"}, E_IREN, E_ALL);
    tick(); check_outs({name, "_decode"}, E_NONE, E_ALL);
    tick(); check_outs({name, "_exec"}, E_AS | size_bit, E_ALL);
    tick();
    if (is_load) begin
      check_outs({name, "_mem"}, E_AS | size_bit | E_RD, E_ALL);
      tick();
      check_outs({name, "_wb"}, E_RD | E_RW | E_M2R_RAM | E_PCEN,
                 E_ALL & ~(E_AS | E_BYTE | E_HALF | E_WORD));
    end else begin
      check_outs({name, "_mem"}, E_AS | size_bit | E_WR | E_PCEN, E_ALL);
    end
    tick();
    exp_instret = exp_instret + 32'd1;
    check({name, "_instret"}, bus.instret, exp_instret);
    #1 check_outs({name, "_next_fetch"}, E_IREN, E_ALL);
  endtask

  initial begin
    vecs[0] = '{"add",    32'h00308133, 1'b0, E_PCEN | E_RW,                          1'b1};
    vecs[1] = '{"addi",   32'h00508093, 1'b0, E_PCEN | E_RW | E_AS,                   1'b1};
    vecs[2] = '{"auipc",  32'h00001297, 1'b0, E_PCEN | E_RW | E_AS,                   1'b1};
    vecs[3] = '{"lui",    32'h123452B7, 1'b0, E_PCEN | E_RW | E_M2R_IMM,              1'b1};
    vecs[4] = '{"bne_t",  32'h00209463, 1'b1, E_PCEN | E_SEL_BR,                      1'b1};
    vecs[5] = '{"beq_nt", 32'h00208463, 1'b0, E_PCEN | E_SEL_BR,                      1'b1};
    vecs[6] = '{"jal",    32'h008000EF, 1'b0, E_PCEN | E_RW | E_M2R_LINK | E_SEL_JAL, 1'b1};
    vecs[7] = '{"jalr",   32'h000100E7, 1'b0, E_PCEN | E_RW | E_M2R_LINK | E_SEL_JALR | E_AS, 1'b1};
    vecs[8] = '{"ill_ff", 32'hFFFFFFFF, 1'b0, E_PCEN | E_ILL,                         1'b0};
    vecs[9] = '{"ill_00", 32'h00000000, 1'b0, E_PCEN | E_ILL,                         1'b0};

    // Reset held with run=1 and a SYSTEM word on the IR: outputs must still be 0
    rst_n             = 1'b0;
    rst4_n            = 1'b0;
    bus.run           = 1'b1;
    bus.irOut         = IR_ECALL;
    bus.comparatorOut = 1'b1;
    bus4.run           = 1'b1;
    bus4.irOut         = IR_ADD;
    bus4.comparatorOut = 1'b0;
    #3;
    check_outs("reset_outs", E_NONE, E_ALL);
    check("reset_instret", bus.instret, 32'd0);
    check("reset_instret4", 32'(bus4.instret), 32'd0);
    tick();
    check_outs("reset_hold", E_NONE, E_ALL);

    // Release with run=0: controller idles in FETCH
    bus.run   = 1'b0;
    bus.irOut = IR_ADD;
    rst_n     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_outs("idle_fetch", E_NONE, E_ALL);
      check("idle_instret", bus.instret, 32'd0);
    end

    // Table: three-cycle instructions, back to back
    for (int i = 0; i < 10; i++) begin
      bus.irOut         = vecs[i].ir;
      bus.comparatorOut = vecs[i].cmp;
      bus.run           = 1'b1;
      #1 check_outs({vecs[i].name, "_fetch"}, E_IREN, E_ALL);
      tick(); check_outs({vecs[i].name, "_decode"}, E_NONE, E_ALL);
      tick(); check_outs({vecs[i].name, "_exec"}, vecs[i].exp, E_ALL);
      tick();
      if (vecs[i].retire) exp_instret = exp_instret + 32'd1;
      check({vecs[i].name, "_instret"}, bus.instret, exp_instret);
    end

    // Memory operations
    do_mem("lw", IR_LW, 1'b1, E_WORD);
    do_mem("sb", IR_SB, 1'b0, E_BYTE);
    do_mem("sh", IR_SH, 1'b0, E_HALF);

    // run dropped mid-instruction: instruction completes, then stall in FETCH
    bus.irOut = IR_ADD;
    bus.run   = 1'b1;
    tick();
    bus.run = 1'b0;
    tick();
    #1 check_outs("stall_exec", E_PCEN | E_RW, E_ALL);
    tick();
    exp_instret = exp_instret + 32'd1;
    check("stall_instret", bus.instret, exp_instret);
    #1 check_outs("stall_fetch0", E_NONE, E_ALL);
    tick();
    check_outs("stall_fetch1", E_NONE, E_ALL);
    check("stall_instret_hold", bus.instret, exp_instret);

    // Reset during MEM of a store: write strobe drops at once
    bus.irOut = IR_SB;
    bus.run   = 1'b1;
    tick(); tick(); tick();
    check_outs("rst_store_mem", E_AS | E_BYTE | E_WR | E_PCEN, E_ALL);
    rst_n = 1'b0;
    #1 check_outs("rst_store_drop", E_NONE, E_ALL);
    exp_instret = '0;
    check("rst_store_instret", bus.instret, exp_instret);
    tick();
    bus.irOut = IR_ADD;
    rst_n     = 1'b1;
    #1 check_outs("restart_fetch", E_IREN, E_ALL);
    tick(); tick(); tick();
    exp_instret = exp_instret + 32'd1;
    check("restart_instret", bus.instret, exp_instret);

    // ECALL: no strobes in EXEC, then halted until reset
    bus.irOut = IR_ECALL;
    #1 check_outs("ecall_fetch", E_IREN, E_ALL);
    tick(); check_outs("ecall_decode", E_NONE, E_ALL);
    tick(); check_outs("ecall_exec", E_NONE, E_ALL);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_outs("halt_state", E_HALT, E_ALL);
      check("halt_instret", bus.instret, exp_instret);
    end
    rst_n = 1'b0;
    #1 check_outs("halt_reset", E_NONE, E_ALL);
    tick();
    bus.irOut = IR_ADD;
    rst_n     = 1'b1;
    #1 check_outs("halt_exit_fetch", E_IREN, E_ALL);

    // Narrow counter: 15 retires reach the top value, the 16th wraps to 0
    rst4_n = 1'b1;
    repeat (45) tick();
    check("wrap_at_max", 32'(bus4.instret), 32'd15);
    repeat (3) tick();
    check("wrap_to_zero", 32'(bus4.instret), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
